// File: rtl/pc_unit.sv
// Program-counter unit with a circular return-address stack and four next-PC modes.
// Optional macro MISALIGN_TRAP_EN turns misaligned targets into a trap instead of masking them.
module pc_unit #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(107),
    parameter int unsigned       INC          = 1,
    parameter int unsigned       RAS_DEPTH    = 4,
    parameter int unsigned       ALIGN        = 0,
    parameter logic [WIDTH-1:0]  TRAP_VECTOR  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pc_write,
    input  logic [1:0]                   mode,
    input  logic                         link,
    input  logic [WIDTH-1:0]             offset,
    input  logic [WIDTH-1:0]             target,
    input  logic                         clr_flags,
    output logic [WIDTH-1:0]             pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output logic                         trap
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << ALIGN) - 64'd1);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [WIDTH-1:0] pc_reg;
    logic [PTR_W-1:0] top_ptr_reg;
    logic [CNT_W-1:0] ras_count_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             trap_reg;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] raw_next;
    logic [WIDTH-1:0] next_pc;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] ras_waddr;
    logic             ras_empty;
    logic             ras_full;
    logic             do_pop;
    logic             do_push;
    logic             ras_we;
    logic             misaligned;
    logic             set_overflow;
    logic             set_underflow;

    always_comb begin
        seq_pc    = pc_reg + WIDTH'(INC);
        ras_empty = (ras_count_reg == '0);
        ras_full  = (ras_count_reg == CNT_W'(RAS_DEPTH));
        top_idx   = top_ptr_reg - PTR_W'(1);
        do_pop    = (mode == 2'd3) && !ras_empty;
        // A linked return reuses the popped slot, so only a plain link moves the pointer up.
        do_push   = link && !do_pop;
        ras_we    = pc_write && link;
        ras_waddr = do_pop ? top_idx : top_ptr_reg;

        raw_next = seq_pc;
        case (mode)
            2'd1:    raw_next = pc_reg + offset;
            2'd2:    raw_next = target;
            2'd3:    raw_next = ras_empty ? seq_pc : ras_mem[top_idx];
            default: raw_next = seq_pc;
        endcase

        misaligned = TRAP_EN && ((raw_next & LOW_MASK) != '0);
        if (misaligned)
            next_pc = TRAP_VECTOR;
        else if (TRAP_EN)
            next_pc = raw_next;
        else
            next_pc = raw_next & ~LOW_MASK;

        set_overflow  = pc_write && do_push && ras_full;
        set_underflow = pc_write && (mode == 2'd3) && ras_empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg        <= RESET_VECTOR;
            top_ptr_reg   <= '0;
            ras_count_reg <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            trap_reg      <= 1'b0;
        end else begin
            trap_reg <= 1'b0;
            if (pc_write) begin
                pc_reg   <= next_pc;
                trap_reg <= misaligned;
                if (do_pop && !link) begin
                    top_ptr_reg   <= top_idx;
                    ras_count_reg <= ras_count_reg - CNT_W'(1);
                end else if (do_push) begin
                    top_ptr_reg <= top_ptr_reg + PTR_W'(1);
                    if (!ras_full)
                        ras_count_reg <= ras_count_reg + CNT_W'(1);
                end
            end
            // A flag raised this cycle takes priority over a clear request.
            if (set_overflow)
                overflow_reg <= 1'b1;
            else if (clr_flags)
                overflow_reg <= 1'b0;
            if (set_underflow)
                underflow_reg <= 1'b1;
            else if (clr_flags)
                underflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && ras_we)
            ras_mem[ras_waddr] <= seq_pc;
    end

    assign pc            = pc_reg;
    assign ras_count     = ras_count_reg;
    assign ras_overflow  = overflow_reg;
    assign ras_underflow = underflow_reg;
    assign trap          = trap_reg;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit and successor to the single-register PC. It holds the current instruction address and computes the next address from one of four modes: sequential, PC-relative branch, absolute jump, and return. Return addresses come from an internal circular return-address stack (RAS). It sits at the head of the fetch stage and feeds the instruction-memory address.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 107, PC value after reset.
- INC, 1, sequential increment added to PC.
- RAS_DEPTH, 4, RAS entries; must be a power of two, ≥2.
- ALIGN, 0, log2 of the required target alignment; 0 means no alignment check.
- TRAP_VECTOR, 0, PC loaded on a misalignment trap (used only with the optional feature).

Ports:
- clk, in, 1, clock; rising edge active.
- reset, in, 1, asynchronous, active-low reset.
- pc_write, in, 1, update enable; 0 holds all state.
- mode, in, 2, next-PC select: 00 seq, 01 branch, 10 jump, 11 return.
- link, in, 1, push pc+INC onto the RAS this update.
- offset, in, WIDTH, signed branch offset (mode 01).
- target, in, WIDTH, absolute jump target (mode 10).
- clr_flags, in, 1, clears the sticky flags.
- pc, out, WIDTH, current instruction address.
- ras_count, out, clog2(RAS_DEPTH)+1, number of valid RAS entries.
- ras_overflow, out, 1, sticky: a push overwrote the oldest entry.
- ras_underflow, out, 1, sticky: a return was issued with the RAS empty.
- trap, out, 1, one-cycle pulse on a misaligned target (optional feature only).

Behaviour:
- reset low, asynchronously: pc=RESET_VECTOR, ras_count=0, top pointer=0, ras_overflow=0, ras_underflow=0, trap=0. RAS contents are don't-care.
- Updates occur only at posedge clk with reset high and pc_write=1. Latency is one cycle: pc reflects the new value in the cycle after the sampling edge.
- pc_write=0: pc and the RAS hold; mode, link and offset are ignored. clr_flags still acts.
- Next-PC computation:
  - mode 00: pc+INC.
  - mode 01: pc+offset, two's complement.
  - mode 10: target.
  - mode 11: if ras_count>0, the top entry, then pop. If empty, pc+INC, and ras_underflow is set.
- All arithmetic is modulo 2^WIDTH; carry is discarded, so wrap-around is legal.
- link=1 pushes pc+INC, the value before the update.
  - Not full: the entry is written and ras_count increments.
  - Full (ras_count=RAS_DEPTH): circular overwrite of the oldest entry; ras_count stays at RAS_DEPTH; ras_overflow is set.
- mode 11 with link=1 in the same update is a swap: the popped top is the next PC, pc+INC replaces that top slot, and ras_count is unchanged. If the RAS is empty, this case behaves as underflow followed by a push.
- clr_flags=1 clears both sticky flags. A flag set in the same cycle wins over the clear.
- Only the pointer and count change on a pop; entry data is not cleared.
- Without MISALIGN_TRAP_EN: when ALIGN>0, the low ALIGN bits of the computed next PC are forced to 0 in all modes.

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined, with ALIGN>0: if the computed next PC has any low ALIGN bits nonzero, pc=TRAP_VECTOR and trap pulses high for exactly one cycle, aligned with the new pc. The RAS push/pop for that update still occurs.
- Undefined: the trap port is tied to 0 and low bits are forced to 0 as described under Behaviour.

Test Plan:
- Reset, then 3 updates with mode=00 → pc = 107, 108, 109, 110. Assert reset low mid-run → pc becomes 107 immediately, without waiting for clk.
- At pc=200, mode=01, offset=-50 → pc=150. At pc=2^32-1, mode=00 → pc=0 (wrap).
- pc_write=0 for 5 cycles with mode=10, target=0x1000 → pc unchanged and ras_count unchanged.
- Call/return: at pc=10, mode=10, target=500, link=1 → pc=500, ras_count=1. Then mode=11 → pc=11, ras_count=0. Another mode=11 → pc=12 and ras_underflow=1. Then clr_flags=1 → flag clears.
- RAS_DEPTH=4: issue 5 linked jumps from pcs 1, 2, 3, 4, 5 → ras_overflow=1, ras_count=4. Then 4 returns → pc = 6, 5, 4, 3 (the entry for return address 2 was overwritten).
- With MISALIGN_TRAP_EN, ALIGN=2, TRAP_VECTOR=0x80: mode=10, target=0x102 → pc=0x80, trap high for one cycle. Without the macro, the same stimulus gives pc=0x100 and trap=0.
